// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one op at a time on a valid/ready port.
// Ports: exec req (ReqValid/ReqReady + op), mem req/resp, completion bundle.
module lsu_mem_stage #(
  parameter int MaxWait = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [4:0]  Rd,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic [31:0] MemAddr,
  output logic        MemWE,
  output logic [3:0]  MemByteEn,
  output logic [31:0] MemWData,
  input  logic        MemRespValid,
  input  logic [31:0] MemRData,
  output logic        DoneValid,
  output logic [31:0] ReadData,
  output logic [4:0]  DoneRd,
  output logic        Fault,
  output logic [1:0]  FaultCause
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0] LastWait = 8'(MaxWait - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [4:0]  r_rd;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic [1:0]  r_cause;
  logic [7:0]  r_cnt;

  logic        w_illegal;
  logic        w_misal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_ext;
  logic        w_accept;
  logic        w_tmo;

  assign w_accept = (r_state == IDLE) && ReqValid;
  assign w_tmo    = (r_cnt == LastWait);

  // Stores only have SB/SH/SW; loads also allow LBU/LHU.
  always_comb begin
    w_illegal = 1'b0;
    if (MemWrite)
      w_illegal = (Funct3 > 3'd2);
    else
      w_illegal = (Funct3 == 3'd3) || (Funct3[2:1] == 2'b11);
  end

  always_comb begin
    w_misal = 1'b0;
    unique case (1'b1)
      (Funct3[1:0] == 2'b01): w_misal = ALUResult[0];
      (Funct3[1:0] == 2'b10): w_misal = (ALUResult[1:0] != 2'b00);
      default:                w_misal = 1'b0;
    endcase
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WriteData;
    unique case (1'b1)
      (Funct3[1:0] == 2'b00): begin
        w_be    = 4'b0001 << ALUResult[1:0];
        w_wdata = {4{WriteData[7:0]}};
      end
      (Funct3[1:0] == 2'b01): begin
        w_be    = 4'b0011 << ALUResult[1:0];
        w_wdata = {2{WriteData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteData;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend.
  assign w_shift = MemRData >> {r_off, 3'b000};

  always_comb begin
    w_ext = MemRData;
    unique case (1'b1)
      (r_f3 == 3'b000): w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      (r_f3 == 3'b001): w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      (r_f3 == 3'b100): w_ext = {24'd0, w_shift[7:0]};
      (r_f3 == 3'b101): w_ext = {16'd0, w_shift[15:0]};
      default:          w_ext = MemRData;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (ReqValid)
          w_next = (w_illegal || w_misal) ? DONE : REQ;
      end
      REQ: begin
        if (MemReqReady)
          w_next = r_we ? DONE : WAIT;
      end
      WAIT: begin
        if (MemRespValid || w_tmo)
          w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_off   <= 2'd0;
      r_rd    <= 5'd0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_fault <= 1'b0;
      r_cause <= 2'b00;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= MemWrite;
        r_f3    <= Funct3;
        r_off   <= ALUResult[1:0];
        r_rd    <= Rd;
        r_addr  <= {ALUResult[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_rdata <= 32'd0;
        r_cnt   <= 8'd0;
        r_fault <= w_illegal || w_misal;
        // Illegal funct3 wins over misalignment.
        r_cause <= w_illegal ? 2'b10 :
                   w_misal   ? 2'b01 : 2'b00;
      end
      if ((r_state == REQ) && MemReqReady)
        r_cnt <= 8'd0;
      if (r_state == WAIT) begin
        if (MemRespValid) begin
          r_rdata <= w_ext;
        end else if (w_tmo) begin
          r_fault <= 1'b1;
          r_cause <= 2'b11;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign ReqReady    = (r_state == IDLE);
  assign MemReqValid = (r_state == REQ);
  assign MemAddr     = r_addr;
  assign MemWE       = r_we;
  assign MemByteEn   = r_be;
  assign MemWData    = r_wdata;
  assign DoneValid   = (r_state == DONE);
  assign ReadData    = DoneValid ? r_rdata : 32'd0;
  assign DoneRd      = DoneValid ? r_rd : 5'd0;
  assign Fault       = DoneValid && r_fault;
  assign FaultCause  = DoneValid ? r_cause : 2'b00;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: vector table plus timeout, stall and reset runs.
// Memory side is driven directly from the bench each cycle.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] ALUResult = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [4:0]  Rd = 5'd0;
  logic        MemReqValid;
  logic        MemReqReady = 1'b0;
  logic [31:0] MemAddr;
  logic        MemWE;
  logic [3:0]  MemByteEn;
  logic [31:0] MemWData;
  logic        MemRespValid = 1'b0;
  logic [31:0] MemRData = 32'd0;
  logic        DoneValid;
  logic [31:0] ReadData;
  logic [4:0]  DoneRd;
  logic        Fault;
  logic [1:0]  FaultCause;

  always #5 clk = ~clk;

  lsu_mem_stage #(.MaxWait(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .Rd(Rd),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
    .MemAddr(MemAddr), .MemWE(MemWE),
    .MemByteEn(MemByteEn), .MemWData(MemWData),
    .MemRespValid(MemRespValid), .MemRData(MemRData),
    .DoneValid(DoneValid), .ReadData(ReadData),
    .DoneRd(DoneRd), .Fault(Fault),
    .FaultCause(FaultCause)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        req;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdout;
    logic        fault;
    logic [1:0]  cause;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  int n_pass = 0;
  int n_tot  = 0;

  bit          g_sreq;
  logic [3:0]  g_be;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        g_we;
  logic [31:0] g_rdata;
  logic        g_fault;
  logic [1:0]  g_cause;
  logic [4:0]  g_rd;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd);
    @(negedge clk);
    chk("req_ready", ReqReady, 1);
    ReqValid  = 1'b1;
    MemWrite  = we;
    Funct3    = f3;
    ALUResult = addr;
    WriteData = wd;
    Rd        = rd;
    @(posedge clk);
    #1 ReqValid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat    = 0;
    g_sreq = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (MemReqValid && !g_sreq) begin
        g_sreq  = 1'b1;
        g_be    = MemByteEn;
        g_addr  = MemAddr;
        g_wdata = MemWData;
        g_we    = MemWE;
      end
      if (DoneValid) begin
        lat     = k;
        g_rdata = ReadData;
        g_fault = Fault;
        g_cause = FaultCause;
        g_rd    = DoneRd;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int dv;
    bit stable;

    vecs[0]  = '{0, 3'b000, 32'h1003, 32'h0, 5'd1, 32'h80AABBCC,
                 1, 4'b1000, 32'h1000, 32'h0, 32'hFFFFFF80, 0, 2'b00, 3};
    vecs[1]  = '{0, 3'b101, 32'h2002, 32'h0, 5'd2, 32'hBEEF1234,
                 1, 4'b1100, 32'h2000, 32'h0, 32'h0000BEEF, 0, 2'b00, 3};
    vecs[2]  = '{1, 3'b000, 32'h0001, 32'h123456A5, 5'd3, 32'h0,
                 1, 4'b0010, 32'h0, 32'hA5A5A5A5, 32'h0, 0, 2'b00, 2};
    vecs[3]  = '{0, 3'b010, 32'h0006, 32'h0, 5'd4, 32'h0,
                 0, 4'b0, 32'h0, 32'h0, 32'h0, 1, 2'b01, 1};
    vecs[4]  = '{1, 3'b100, 32'h0010, 32'h0, 5'd5, 32'h0,
                 0, 4'b0, 32'h0, 32'h0, 32'h0, 1, 2'b10, 1};
    vecs[5]  = '{0, 3'b001, 32'h3000, 32'h0, 5'd6, 32'h12348001,
                 1, 4'b0011, 32'h3000, 32'h0, 32'hFFFF8001, 0, 2'b00, 3};
    vecs[6]  = '{0, 3'b100, 32'h4002, 32'h0, 5'd7, 32'h00F00000,
                 1, 4'b0100, 32'h4000, 32'h0, 32'h000000F0, 0, 2'b00, 3};
    vecs[7]  = '{0, 3'b010, 32'h5004, 32'h0, 5'd8, 32'hDEADBEEF,
                 1, 4'b1111, 32'h5004, 32'h0, 32'hDEADBEEF, 0, 2'b00, 3};
    vecs[8]  = '{1, 3'b001, 32'h0102, 32'hAAAA5678, 5'd9, 32'h0,
                 1, 4'b1100, 32'h0100, 32'h56785678, 32'h0, 0, 2'b00, 2};
    vecs[9]  = '{1, 3'b010, 32'h0200, 32'hCAFEF00D, 5'd10, 32'h0,
                 1, 4'b1111, 32'h0200, 32'hCAFEF00D, 32'h0, 0, 2'b00, 2};
    vecs[10] = '{0, 3'b111, 32'h0003, 32'h0, 5'd11, 32'h0,
                 0, 4'b0, 32'h0, 32'h0, 32'h0, 1, 2'b10, 1};
    vecs[11] = '{1, 3'b001, 32'h0001, 32'h0, 5'd12, 32'h0,
                 0, 4'b0, 32'h0, 32'h0, 32'h0, 1, 2'b01, 1};
    vecs[12] = '{0, 3'b011, 32'h0000, 32'h0, 5'd13, 32'h0,
                 0, 4'b0, 32'h0, 32'h0, 32'h0, 1, 2'b10, 1};
    vecs[13] = '{0, 3'b000, 32'h0010, 32'h0, 5'd14, 32'h0000007F,
                 1, 4'b0001, 32'h0010, 32'h0, 32'h0000007F, 0, 2'b00, 3};
    vecs[14] = '{0, 3'b001, 32'h0022, 32'h0, 5'd15, 32'h7FFF0000,
                 1, 4'b1100, 32'h0020, 32'h0, 32'h00007FFF, 0, 2'b00, 3};

    @(negedge clk);
    chk("rst_ReqReady", ReqReady, 1);
    chk("rst_MemReqValid", MemReqValid, 0);
    chk("rst_MemAddr", MemAddr, 0);
    chk("rst_MemWE", MemWE, 0);
    chk("rst_MemByteEn", MemByteEn, 0);
    chk("rst_MemWData", MemWData, 0);
    chk("rst_DoneValid", DoneValid, 0);
    chk("rst_ReadData", ReadData, 0);
    chk("rst_DoneRd", DoneRd, 0);
    chk("rst_Fault", Fault, 0);
    chk("rst_FaultCause", FaultCause, 0);
    rst_n = 1'b1;

    MemReqReady  = 1'b1;
    MemRespValid = 1'b1;
    foreach (vecs[i]) begin
      MemRData = vecs[i].rdata;
      issue(vecs[i].we, vecs[i].f3, vecs[i].addr,
            vecs[i].wdata, vecs[i].rd);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_memreq", i), g_sreq, vecs[i].req);
      if (vecs[i].req) begin
        chk($sformatf("v%0d_byteen", i), g_be, vecs[i].be);
        chk($sformatf("v%0d_addr", i), g_addr, vecs[i].maddr);
        chk($sformatf("v%0d_wdata", i), g_wdata, vecs[i].mwdata);
        chk($sformatf("v%0d_we", i), g_we, vecs[i].we);
      end
      chk($sformatf("v%0d_rdata", i), g_rdata, vecs[i].rdout);
      chk($sformatf("v%0d_fault", i), g_fault, vecs[i].fault);
      chk($sformatf("v%0d_cause", i), g_cause, vecs[i].cause);
      chk($sformatf("v%0d_rd", i), g_rd, vecs[i].rd);
    end

    // Timeout: 4 WAIT cycles (2..5), DoneValid in cycle 6.
    MemRespValid = 1'b0;
    MemRData     = 32'h55AA55AA;
    issue(0, 3'b010, 32'h40, 32'h0, 5'd17);
    wait_done(lat);
    chk("tmo_latency", lat, 6);
    chk("tmo_fault", g_fault, 1);
    chk("tmo_cause", g_cause, 2'b11);
    chk("tmo_rdata", g_rdata, 0);
    MemRespValid = 1'b1;
    dv = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (DoneValid) dv++;
    end
    chk("tmo_late_resp", dv, 0);
    chk("tmo_ready_after", ReqReady, 1);
    MemRespValid = 1'b0;

    // Stall: MemReqReady low for cycles 1..6, accepted in cycle 7.
    MemReqReady = 1'b0;
    issue(1, 3'b010, 32'h84, 32'h01020304, 5'd18);
    stable = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k <= 7) begin
        if (!(MemReqValid && MemAddr == 32'h84 &&
              MemByteEn == 4'hF && MemWData == 32'h01020304))
          stable = 1'b0;
        if (k == 7) MemReqReady = 1'b1;
      end
      if (DoneValid) begin
        lat = k;
        break;
      end
    end
    chk("stall_stable", stable, 1);
    chk("stall_latency", lat, 8);

    // Reset pulse while in WAIT.
    MemRespValid = 1'b0;
    issue(0, 3'b010, 32'h20, 32'h0, 5'd19);
    @(negedge clk);
    @(negedge clk);
    chk("wait_reqvalid", MemReqValid, 0);
    chk("wait_ready", ReqReady, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ReqReady", ReqReady, 1);
    chk("arst_DoneValid", DoneValid, 0);
    chk("arst_MemByteEn", MemByteEn, 0);
    chk("arst_MemAddr", MemAddr, 0);
    chk("arst_MemWE", MemWE, 0);
    chk("arst_FaultCause", FaultCause, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    MemRespValid = 1'b1;
    dv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (DoneValid) dv++;
    end
    chk("arst_no_done", dv, 0);
    chk("arst_ready_after", ReqReady, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
